// File: rtl/mem_line_fill.sv
// mem_line_fill: read-side line-fill initiator.
// Fetches one cache line of WORDS_PER_LINE consecutive words from the
// multi-cycle memory model, one word per access strobe, assembles them into
// a line buffer and pulses o_fill_done for one cycle when the line is whole.
//
// Handshake with memory: while busy in READ, o_mem_addr is held stable until
// the memory reports i_mem_access. i_mem_read_ok qualifies that strobe: when
// high, i_mem_read_data is captured into the current word and the address
// advances; when low, the same address is retried (no limit on retries).
// The request side is a plain level: i_fill_req is looked at only in IDLE,
// and anything asserted while busy is dropped, not queued.
module mem_line_fill #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 64,
  parameter int WORDS_PER_LINE = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_arst,
  input  logic                                 i_fill_req,
  input  logic [ADDR_WIDTH-1:0]                i_fill_addr,
  output logic                                 o_fill_busy,
  output logic                                 o_fill_done,
  output logic [ADDR_WIDTH-1:0]                o_line_addr,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] o_line_data,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  output logic                                 o_mem_write_en,
  input  logic [DATA_WIDTH-1:0]                i_mem_read_data,
  input  logic                                 i_mem_access,
  input  logic                                 i_mem_read_ok
);

  // Word index width and the number of byte-offset bits inside one line.
  localparam int CW  = $clog2(WORDS_PER_LINE);
  localparam int OFF = CW + 2;

  // Clears the in-line byte offset of a request to get the line base.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS_PER_LINE - 1);

  // FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Elaboration-time guard: the line must be a power of two of at least two
  // words, otherwise the base masking and the counter wrap do not line up.
  if ((WORDS_PER_LINE < 2) || ((1 << CW) != WORDS_PER_LINE)) begin : g_bad_words
    $error("mem_line_fill: WORDS_PER_LINE must be a power of two >= 2");
  end

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0] req_base;
  logic [ADDR_WIDTH-1:0] next_off;
  logic                  busy_q, busy_d;
  logic                  good_strobe;
  logic                  word_we;

  assign req_base    = i_fill_addr & LINE_MASK;
  assign cnt_inc     = cnt_q + CNT_ONE;
  assign good_strobe = i_mem_access & i_mem_read_ok;

  // Offset of the next word inside the line. The base is aligned, so OR-ing
  // the offset in can never carry out of the line.
  assign next_off = {{(ADDR_WIDTH-OFF){1'b0}}, cnt_inc, 2'b00};

  // Next-state logic for the fill sequencer and its address/counter state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    word_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_fill_req) begin
          state_d     = ST_READ;
          cnt_d       = CNT_ZERO;
          line_addr_d = req_base;
          mem_addr_d  = req_base;
          busy_d      = 1'b1;
        end
      end
      ST_READ: begin
        // A failed strobe falls through untouched: same word, same address.
        if (good_strobe) begin
          word_we = 1'b1;
          if (cnt_q == CNT_LAST) begin
            // Address is left on the last word; it only moves on a new fill.
            state_d = ST_DONE;
          end else begin
            cnt_d      = cnt_inc;
            mem_addr_d = line_addr_q | next_off;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state registers; reset abandons any fill in flight.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      line_addr_q <= '0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_addr_q <= line_addr_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
    end
  end

  // Line buffer: one register per word, written in place when its index is
  // current. Words are not cleared at fill start, so a partially refilled
  // line mixes old and new words until the done pulse.
  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_word
    localparam logic [CW-1:0] K_IDX = CW'(k);
    logic [DATA_WIDTH-1:0] word_q;

    // Capture the memory data on a good strobe aimed at this word.
    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
        word_q <= '0;
      end else if (word_we && (cnt_q == K_IDX)) begin
        word_q <= i_mem_read_data;
      end
    end

    assign o_line_data[k*DATA_WIDTH +: DATA_WIDTH] = word_q;
  end

  assign o_fill_busy    = busy_q;
  assign o_fill_done    = (state_q == ST_DONE);
  assign o_line_addr    = line_addr_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_write_en = 1'b0;

endmodule

// File: tb/tb_mem_line_fill.sv
// tb_mem_line_fill: directed bench for mem_line_fill (16 x 32-bit words).
// The memory model returns the low 32 bits of the byte address as data on a
// good read and the inverted address on a failed one, so a word written on a
// retry strobe shows up as a wrong word.
module tb_mem_line_fill;

  localparam int W   = 16;
  localparam int DW  = 32;
  localparam int AW  = 64;
  localparam int BUDGET = 8 * W * 2 + 20;

  logic              i_clk;
  logic              i_arst;
  logic              i_fill_req;
  logic [AW-1:0]     i_fill_addr;
  logic              o_fill_busy;
  logic              o_fill_done;
  logic [AW-1:0]     o_line_addr;
  logic [DW*W-1:0]   o_line_data;
  logic [AW-1:0]     o_mem_addr;
  logic              o_mem_write_en;
  logic [DW-1:0]     i_mem_read_data;
  logic              i_mem_access;
  logic              i_mem_read_ok;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] addr;
    int          period;
    int          bad_word;
    int          mid_req_cyc;
    logic [63:0] base;
    int          exp_lat;
  } fill_vec_t;

  fill_vec_t vecs[6];

  mem_line_fill #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(W)) dut (
    .i_clk           (i_clk),
    .i_arst          (i_arst),
    .i_fill_req      (i_fill_req),
    .i_fill_addr     (i_fill_addr),
    .o_fill_busy     (o_fill_busy),
    .o_fill_done     (o_fill_done),
    .o_line_addr     (o_line_addr),
    .o_line_data     (o_line_data),
    .o_mem_addr      (o_mem_addr),
    .o_mem_write_en  (o_mem_write_en),
    .i_mem_read_data (i_mem_read_data),
    .i_mem_access    (i_mem_access),
    .i_mem_read_ok   (i_mem_read_ok)
  );

  // Clock / reset block.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Combinational memory model.
  always_comb begin
    if (i_mem_read_ok) i_mem_read_data = o_mem_addr[31:0];
    else               i_mem_read_data = ~o_mem_addr[31:0];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_line(input logic [63:0] base);
    logic [31:0] b32;
    b32 = base[31:0];
    chk("line_addr", o_line_addr, base);
    for (int k = 0; k < W; k++) begin
      chk($sformatf("word%0d", k), 64'(o_line_data[k*DW +: DW]), 64'(b32 + 32'(4 * k)));
    end
  endtask

  // Strobe every cycle until done; lat = cycles after the accept edge, 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (o_fill_done) begin
        lat = cyc;
        break;
      end
      tick();
    end
  endtask

  // Driver + scoreboard for one table vector.
  task automatic run_fill(input fill_vec_t v);
    logic [63:0] exp_q[$];
    int exp_cnt  = 0;
    int done_cyc = 0;
    bit retried  = 0;
    bit strobe;
    bit ok;
    for (int k = 0; k < W; k++) exp_q.push_back(v.base + 64'(4 * k));
    i_fill_addr   = v.addr;
    i_fill_req    = 1'b1;
    i_mem_access  = 1'b0;
    i_mem_read_ok = 1'b0;
    tick();
    i_fill_req = 1'b0;
    for (int cyc = 1; cyc <= BUDGET && done_cyc == 0; cyc++) begin
      if (o_fill_done) begin
        done_cyc = cyc;
      end else begin
        chk("busy_in_read", 64'(o_fill_busy), 64'd1);
        chk("mem_addr", o_mem_addr, (exp_q.size() > 0) ? exp_q[0] : 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mem_write_en", 64'(o_mem_write_en), 64'd0);
        i_fill_req  = (cyc == v.mid_req_cyc);
        i_fill_addr = (cyc == v.mid_req_cyc) ? 64'h9000 : v.addr;
        strobe = ((cyc % v.period) == 0);
        ok     = strobe && !((exp_cnt == v.bad_word) && !retried);
        if (strobe && !ok) retried = 1;
        i_mem_access  = strobe;
        i_mem_read_ok = ok;
        tick();
        if (strobe && ok) begin
          exp_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
    i_fill_req    = 1'b0;
    i_mem_access  = 1'b0;
    i_mem_read_ok = 1'b0;
    chk("done_latency", 64'(done_cyc), 64'(v.exp_lat));
    chk("busy_in_done", 64'(o_fill_busy), 64'd1);
    check_line(v.base);
    tick();
    chk("done_one_pulse", 64'(o_fill_done), 64'd0);
    chk("busy_after_done", 64'(o_fill_busy), 64'd0);
    tick();
    chk("no_queued_fill", 64'(o_fill_busy), 64'd0);
  endtask

  initial begin
    int lat;
    bit spurious;

    vecs[0] = '{64'h1004,             1, -1, 0, 64'h1000,             17};
    vecs[1] = '{64'h2FFC,             8, -1, 0, 64'h2FC0,            129};
    vecs[2] = '{64'h1000,             1,  5, 0, 64'h1000,             18};
    vecs[3] = '{64'h0000_0001_0000_007F, 2, 15, 0, 64'h0000_0001_0000_0040, 35};
    vecs[4] = '{64'h0,                3,  0, 0, 64'h0,                52};
    vecs[5] = '{64'h4008,             1, -1, 4, 64'h4000,             17};

    // Reset with random inputs, including fill requests.
    i_arst        = 1'b1;
    i_fill_req    = 1'b0;
    i_fill_addr   = '0;
    i_mem_access  = 1'b0;
    i_mem_read_ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_fill_req    = 1'($urandom_range(0, 1));
      i_fill_addr   = {$urandom, $urandom};
      i_mem_access  = 1'($urandom_range(0, 1));
      i_mem_read_ok = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_busy", 64'(o_fill_busy), 64'd0);
    chk("rst_done", 64'(o_fill_done), 64'd0);
    chk("rst_line_addr", o_line_addr, 64'd0);
    chk("rst_mem_addr", o_mem_addr, 64'd0);
    chk("rst_write_en", 64'(o_mem_write_en), 64'd0);
    chk("rst_line_data_zero", 64'(o_line_data == '0), 64'd1);
    chk("rst_state_idle", 64'(dut.state_q), 64'd0);
    i_fill_req    = 1'b0;
    i_mem_access  = 1'b0;
    i_mem_read_ok = 1'b0;
    tick();
    i_arst = 1'b0;
    tick();
    tick();
    chk("no_fill_from_reset_req", 64'(o_fill_busy), 64'd0);

    // Table-driven fills.
    for (int i = 0; i < 6; i++) run_fill(vecs[i]);

    // Request held high through DONE: a new fill starts right after.
    i_fill_addr = 64'h5000;
    i_fill_req  = 1'b1;
    tick();
    i_fill_addr   = 64'h6010;
    i_mem_access  = 1'b1;
    i_mem_read_ok = 1'b1;
    wait_done(lat);
    chk("hold_first_latency", 64'(lat), 64'd17);
    check_line(64'h5000);
    tick();
    chk("hold_idle_busy", 64'(o_fill_busy), 64'd0);
    chk("hold_idle_done", 64'(o_fill_done), 64'd0);
    tick();
    chk("hold_second_busy", 64'(o_fill_busy), 64'd1);
    chk("hold_second_line_addr", o_line_addr, 64'h6000);
    chk("hold_second_mem_addr", o_mem_addr, 64'h6000);
    i_fill_req = 1'b0;
    wait_done(lat);
    chk("hold_second_latency", 64'(lat), 64'd17);
    check_line(64'h6000);
    i_mem_access  = 1'b0;
    i_mem_read_ok = 1'b0;
    tick();
    tick();

    // Reset in the middle of a fill (word 7 presented).
    i_fill_addr = 64'h7014;
    i_fill_req  = 1'b1;
    tick();
    i_fill_req    = 1'b0;
    i_mem_access  = 1'b1;
    i_mem_read_ok = 1'b1;
    repeat (7) tick();
    chk("midrst_word7_addr", o_mem_addr, 64'h701C);
    #1;
    i_arst = 1'b1;
    #1;
    chk("midrst_busy", 64'(o_fill_busy), 64'd0);
    chk("midrst_done", 64'(o_fill_done), 64'd0);
    chk("midrst_line_addr", o_line_addr, 64'd0);
    chk("midrst_mem_addr", o_mem_addr, 64'd0);
    chk("midrst_line_data_zero", 64'(o_line_data == '0), 64'd1);
    i_mem_access  = 1'b0;
    i_mem_read_ok = 1'b0;
    tick();
    i_arst   = 1'b0;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_fill_done || o_fill_busy) spurious = 1;
      tick();
    end
    chk("midrst_no_done_after", 64'(spurious), 64'd0);
    run_fill('{64'h7014, 1, -1, 0, 64'h7000, 17});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
